pwm_dt_core: RTL and testbench

//  Counter-based PWM engine with complementary high/low-side outputs and programmable dead time.

---
 rtl/pwm_dt_core.sv | 95 +++++++++
 tb/tb_pwm_dt_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dt_core.sv
// pwm_dt_core: counter PWM with complementary outputs, dead time and double-buffered config
module pwm_dt_core #(
  parameter int WIDTH = 8,
  parameter int DT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  input  logic [DT_W-1:0]  cfg_dead,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic             period_start
);
  typedef enum logic [3:0] {
    S_OFF  = 4'b0001,
    S_H    = 4'b0010,
    S_L    = 4'b0100,
    S_DEAD = 4'b1000
  } state_t;
  state_t           r_state, w_state_nxt, w_side;
  logic [WIDTH-1:0] r_cnt, r_period, r_duty, r_sh_period, r_sh_duty;
  logic [DT_W-1:0]  r_dead, r_sh_dead, r_dt, w_dt_nxt;
  logic             r_pending, r_pstart;
  logic             w_wrap, w_raw, w_apply, w_accept, w_edge;
  assign w_wrap       = r_cnt == r_period;
  assign w_raw        = r_cnt < r_duty;
  assign w_accept     = cfg_valid & ~r_pending;
  assign w_apply      = r_pending & (~en | w_wrap);
  assign w_side       = w_raw ? S_H : S_L;
  assign w_edge       = (r_state == S_OFF) | (r_state == S_H & ~w_raw) | (r_state == S_L & w_raw);
  assign cfg_ready    = ~r_pending;
  assign pwm_h        = r_state[1];
  assign pwm_l        = r_state[2];
  assign period_start = r_pstart;
  // shadow capture on handshake, shadow-to-active only at a period boundary or while stopped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_period <= '0;
      r_sh_duty   <= '0;
      r_sh_dead   <= '0;
      r_pending   <= 1'b0;
      r_period    <= '1;
      r_duty      <= '0;
      r_dead      <= '0;
    end else if (w_accept) begin
      r_sh_period <= cfg_period;
      r_sh_duty   <= cfg_duty;
      r_sh_dead   <= cfg_dead;
      r_pending   <= 1'b1;
    end else if (w_apply) begin
      r_period    <= r_sh_period;
      r_duty      <= r_sh_duty;
      r_dead      <= r_sh_dead;
      r_pending   <= 1'b0;
    end
  end
  // period counter, held at zero while disabled; start pulse follows the zero count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_pstart <= 1'b0;
    end else begin
      r_cnt    <= (!en || w_wrap) ? '0 : r_cnt + 1'b1;
      r_pstart <= en & (r_cnt == '0);
    end
  end
  // every phase change passes through r_dead low/low cycles before the new side drives
  always_comb begin
    w_state_nxt = r_state;
    w_dt_nxt    = r_dt;
    if (!en) begin
      w_state_nxt = S_OFF;
    end else if (w_edge) begin
      w_state_nxt = (r_dead == '0) ? w_side : S_DEAD;
      w_dt_nxt    = r_dead - 1'b1;
    end else if (r_state == S_DEAD) begin
      w_state_nxt = (r_dt == '0) ? w_side : S_DEAD;
      w_dt_nxt    = r_dt - 1'b1;
    end
  end
  // one-hot state register; its bits drive the outputs directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OFF;
      r_dt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dt    <= w_dt_nxt;
    end
  end
endmodule

// File: tb/tb_pwm_dt_core.sv
// tb_pwm_dt_core: table, corner-sequence and random checks of pwm_dt_core against a cycle model
module tb_pwm_dt_core;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_period = '0;
  logic [7:0] cfg_duty = '0;
  logic [3:0] cfg_dead = '0;
  logic       cfg_ready, pwm_h, pwm_l, period_start;
  int errors = 0;
  int checks = 0;
  int m_cnt, m_per, m_duty, m_dead, s_per, s_duty, s_dead, m_out, m_gap;
  bit m_pend, m_run, m_ps;
  typedef struct {
    int per;
    int duty;
    int dead;
    int h;
    int l;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  pwm_dt_core #(.WIDTH(8), .DT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_dead(cfg_dead),
    .pwm_h(pwm_h), .pwm_l(pwm_l), .period_start(period_start)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_per = 255; m_duty = 0; m_dead = 0;
    s_per = 0; s_duty = 0; s_dead = 0;
    m_pend = 0; m_out = 0; m_gap = 0; m_run = 0; m_ps = 0;
  endtask

  // m_out: 0 = both low, 1 = high side, 2 = low side; m_gap = dead cycles still owed
  task automatic tick();
    int tgt, g, n_out, n_gap, n_cnt;
    bit n_run, n_ps, acc, app;
    tgt   = (m_cnt < m_duty) ? 1 : 2;
    acc   = cfg_valid && !m_pend;
    app   = m_pend && (!en || m_cnt == m_per);
    n_ps  = en && m_cnt == 0;
    n_cnt = (!en || m_cnt == m_per) ? 0 : m_cnt + 1;
    if (!en) begin
      n_out = 0; n_gap = 0; n_run = 0;
    end else begin
      g     = (!m_run || (m_out != 0 && m_out != tgt)) ? m_dead : m_gap;
      n_out = (g > 0) ? 0 : tgt;
      n_gap = (g > 0) ? g - 1 : 0;
      n_run = 1;
    end
    if (app) begin
      m_per = s_per; m_duty = s_duty; m_dead = s_dead; m_pend = 0;
    end
    if (acc) begin
      s_per = cfg_period; s_duty = cfg_duty; s_dead = cfg_dead; m_pend = 1;
    end
    m_cnt = n_cnt; m_out = n_out; m_gap = n_gap; m_run = n_run; m_ps = n_ps;
    @(posedge clk);
    @(negedge clk);
    chk("pwm_h", pwm_h, m_out == 1);
    chk("pwm_l", pwm_l, m_out == 2);
    chk("period_start", period_start, m_ps);
    chk("cfg_ready", cfg_ready, !m_pend);
    chk("overlap", pwm_h & pwm_l, 0);
  endtask

  task automatic apply_cfg(input int per, input int duty, input int dead);
    en = 0;
    cfg_period = 8'(per); cfg_duty = 8'(duty); cfg_dead = 4'(dead);
    cfg_valid = 1;
    tick();
    cfg_valid = 0;
    tick();
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    while (period_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("ps_sync", period_start, 1);
  endtask

  initial begin
    int hc, lc, pc, low;
    tbl[0] = '{9, 3, 0, 3, 7};
    tbl[1] = '{9, 3, 2, 1, 5};
    tbl[2] = '{9, 0, 0, 0, 10};
    tbl[3] = '{9, 255, 0, 10, 0};
    tbl[4] = '{0, 1, 0, 1, 0};
    tbl[5] = '{9, 6, 1, 5, 3};
    tbl[6] = '{4, 2, 3, 0, 2};
    tbl[7] = '{0, 0, 0, 0, 1};
    model_reset();
    @(negedge clk);
    chk("rst_pwm_h", pwm_h, 0);
    chk("rst_pwm_l", pwm_l, 0);
    chk("rst_ps", period_start, 0);
    chk("rst_ready", cfg_ready, 1);
    rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      apply_cfg(tbl[i].per, tbl[i].duty, tbl[i].dead);
      en = 1;
      repeat (30) tick();
      hc = 0; lc = 0; pc = 0;
      repeat (4 * (tbl[i].per + 1)) begin
        tick();
        hc += int'(pwm_h); lc += int'(pwm_l); pc += int'(period_start);
      end
      chk($sformatf("tbl%0d_high", i), hc, 4 * tbl[i].h);
      chk($sformatf("tbl%0d_low", i), lc, 4 * tbl[i].l);
      chk($sformatf("tbl%0d_starts", i), pc, 4);
    end

    apply_cfg(9, 3, 0);
    en = 1;
    wait_ps();
    repeat (3) tick();
    cfg_period = 9; cfg_duty = 6; cfg_dead = 0; cfg_valid = 1;
    tick();
    low = int'(!cfg_ready);
    cfg_duty = 1;
    tick();
    low += int'(!cfg_ready);
    tick();
    low += int'(!cfg_ready);
    cfg_valid = 0;
    for (int n = 0; n < 20 && !cfg_ready; n++) begin
      tick();
      low += int'(!cfg_ready);
    end
    chk("upd_ready_low", low, 5);
    hc = 0;
    repeat (10) begin
      tick();
      hc += int'(pwm_h);
    end
    chk("upd_new_duty", hc, 6);
    chk("upd_ready_after", cfg_ready, 1);

    apply_cfg(9, 3, 0);
    en = 1;
    wait_ps();
    repeat (4) tick();
    en = 0;
    cfg_period = 9; cfg_duty = 3; cfg_dead = 2; cfg_valid = 1;
    tick();
    chk("stop_h", pwm_h, 0);
    chk("stop_l", pwm_l, 0);
    cfg_valid = 0;
    tick();
    chk("stop_applied", cfg_ready, 1);
    en = 1;
    tick();
    chk("rest_dead1_h", pwm_h, 0);
    chk("rest_dead1_l", pwm_l, 0);
    tick();
    chk("rest_dead2_h", pwm_h, 0);
    chk("rest_dead2_l", pwm_l, 0);
    tick();
    chk("rest_high", pwm_h, 1);

    wait_ps();
    cfg_period = 9; cfg_duty = 5; cfg_dead = 0; cfg_valid = 1;
    tick();
    cfg_valid = 0;
    tick();
    chk("pre_rst_h", pwm_h, 1);
    chk("pre_rst_pending", cfg_ready, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_h", pwm_h, 0);
    chk("arst_l", pwm_l, 0);
    chk("arst_ready", cfg_ready, 1);
    chk("arst_ps", period_start, 0);
    model_reset();
    en = 0;
    #1 rst_n = 1;
    repeat (4) tick();
    chk("post_rst_h", pwm_h, 0);
    chk("post_rst_l", pwm_l, 0);
    en = 1;
    repeat (5) tick();
    chk("post_rst_low_side", pwm_l, 1);

    en = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      cfg_valid = ($urandom_range(0, 5) == 0);
      if (cfg_valid) begin
        cfg_period = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
        cfg_duty   = 8'($urandom_range(0, 32'(cfg_period) + 2));
        cfg_dead   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      end
      tick();
    end
    cfg_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
